// File: rtl/xpb_pkg.sv
// Shared defaults and FSM state type for the xP-multiple table generator.
// The REDUCE state only exists when XPB_GEN_REDUCE_EN is defined.
package xpb_pkg;

   localparam int DATA_BITS_DEF = 1024;
   localparam int ADDR_BITS_DEF = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EMIT   = 2'd1,
`ifdef XPB_GEN_REDUCE_EN
      REDUCE = 2'd2,
`endif
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/xpb_gen_modadd.sv
// Accumulate adder plus the compare/conditional-subtract path of the table generator.
// The modulus path and adder carry are present only with XPB_GEN_REDUCE_EN defined.
module xpb_gen_modadd
   import xpb_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic [DATA_BITS-1:0] acc_i,
   input  logic [DATA_BITS-1:0] addend_i,
`ifdef XPB_GEN_REDUCE_EN
   input  logic                 carry_i,
   input  logic [DATA_BITS-1:0] modulus_i,
   output logic                 carry_o,
   output logic [DATA_BITS-1:0] red_o,
`endif
   output logic [DATA_BITS-1:0] sum_o
);

`ifdef XPB_GEN_REDUCE_EN
   // The carry keeps the true sum (< 2*modulus) so one subtraction always lands in range.
   assign {carry_o, sum_o} = {1'b0, acc_i} + {1'b0, addend_i};
   assign red_o = (carry_i || (acc_i >= modulus_i)) ? (acc_i - modulus_i) : acc_i;
`else
   assign sum_o = acc_i + addend_i;
`endif

endmodule

// File: rtl/xpb_table_gen.sv
// Generates the table j*base (mod modulus, or mod 2^DATA_BITS) for j = 0..2^ADDR_BITS-1.
// Optional modular reduction is compiled in with macro XPB_GEN_REDUCE_EN.
module xpb_table_gen
   import xpb_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int ADDR_BITS = ADDR_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] base,
   input  logic [DATA_BITS-1:0] modulus,
   input  logic                 wr_ready,
   output logic                 wr_en,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [DATA_BITS-1:0] wr_data,
   output logic                 busy,
   output logic                 done
);

   state_t                 state_q;
   logic [ADDR_BITS-1:0]   idx_q;
   logic [DATA_BITS-1:0]   acc_q;
   logic [DATA_BITS-1:0]   base_q;
   logic                   wrEn_q;
   logic                   busy_q;
   logic                   done_q;
   logic [DATA_BITS-1:0]   accSum_d;
   logic                   lastIdx;

`ifdef XPB_GEN_REDUCE_EN
   logic [DATA_BITS-1:0]   mod_q;
   logic                   carry_q;
   logic                   accCarry_d;
   logic [DATA_BITS-1:0]   accRed_d;
`else
   logic                   unusedModulus;
   assign unusedModulus = ^modulus;
`endif

   assign lastIdx = &idx_q;

   xpb_gen_modadd #(
      .DATA_BITS (DATA_BITS)
   ) u_modadd (
      .acc_i     (acc_q),
      .addend_i  (base_q),
`ifdef XPB_GEN_REDUCE_EN
      .carry_i   (carry_q),
      .modulus_i (mod_q),
      .carry_o   (accCarry_d),
      .red_o     (accRed_d),
`endif
      .sum_o     (accSum_d)
   );

   // Single FSM: outputs are registered so reset clears them without a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         acc_q   <= '0;
         base_q  <= '0;
         wrEn_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef XPB_GEN_REDUCE_EN
         mod_q   <= '0;
         carry_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  base_q  <= base;
`ifdef XPB_GEN_REDUCE_EN
                  mod_q   <= modulus;
                  carry_q <= 1'b0;
`endif
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  wrEn_q  <= 1'b1;
                  state_q <= EMIT;
               end
            end
            EMIT: begin
               if (wr_ready) begin
                  if (lastIdx) begin
                     wrEn_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     acc_q <= accSum_d;
`ifdef XPB_GEN_REDUCE_EN
                     carry_q <= accCarry_d;
                     wrEn_q  <= 1'b0;
                     state_q <= REDUCE;
`else
                     idx_q <= idx_q + ADDR_BITS'(1);
`endif
                  end
               end
            end
`ifdef XPB_GEN_REDUCE_EN
            REDUCE: begin
               acc_q   <= accRed_d;
               carry_q <= 1'b0;
               idx_q   <= idx_q + ADDR_BITS'(1);
               wrEn_q  <= 1'b1;
               state_q <= EMIT;
            end
`endif
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign wr_en   = wrEn_q;
   assign wr_addr = idx_q;
   assign wr_data = acc_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard bench for xpb_table_gen: stimulus pushes expected writes, a monitor pops and compares.
// Expected entries follow the build: reduced with XPB_GEN_REDUCE_EN, plain modulo 2^DATA_BITS otherwise.
module tb_xpb_table_gen;
   import xpb_pkg::*;

   localparam int DW    = DATA_BITS_DEF;
   localparam int AW    = ADDR_BITS_DEF;
   localparam int DEPTH = 1 << AW;
`ifdef XPB_GEN_REDUCE_EN
   localparam int GAP = 2;
`else
   localparam int GAP = 1;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] base = '0;
   logic [DW-1:0] modulus = '0;
   logic          wr_ready = 1'b1;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t expQ[$];
   int  testsRun = 0;
   int  testsFailed = 0;
   int  cycle = 0;
   int  tableId = 0;
   int  expGap = 0;

   xpb_table_gen #(
      .DATA_BITS (DW),
      .ADDR_BITS (AW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .modulus  (modulus),
      .wr_ready (wr_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   function automatic logic [DW-1:0] expEntry(int j, logic [DW-1:0] b, logic [DW-1:0] m);
`ifdef XPB_GEN_REDUCE_EN
      logic [DW+7:0] p;
      p = (DW+8)'(j) * {8'h00, b};
      p = p % {8'h00, m};
      return p[DW-1:0];
`else
      logic unusedM;
      unusedM = ^m;
      return DW'(j) * b;
`endif
   endfunction

   task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got hi=%h lo=%h, expected hi=%h lo=%h", name,
                  act[DW-1:DW-64], act[63:0], exp[DW-1:DW-64], exp[63:0]);
      end
   endtask

   // Monitor: samples late in the low phase, after the stimulus has settled wr_ready.
   initial begin
      bit  prevLast = 1'b0;
      bit  haveLast = 1'b0;
      int  lastCycle = 0;
      int  seenTable = 0;
      wr_t e;
      forever begin
         @(negedge clk);
         #3;
         if (seenTable != tableId) begin
            seenTable = tableId;
            haveLast  = 1'b0;
            prevLast  = 1'b0;
         end
         if (!reset) begin
            if (done || prevLast) begin
               checkOutput("done pulse", DW'(done), DW'(prevLast));
               checkOutput("busy during done", DW'(busy), '0);
            end
            prevLast = 1'b0;
            if (wr_en && wr_ready) begin
               if (expQ.size() == 0) begin
                  testsRun++;
                  testsFailed++;
                  $display("[TB] FAIL unexpected write: got addr=%0d, expected no write", wr_addr);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("wr_addr", DW'(wr_addr), DW'(e.addr));
                  checkOutput("wr_data", wr_data, e.data);
               end
               if (expGap != 0 && haveLast)
                  checkOutput("write gap", DW'(cycle - lastCycle), DW'(expGap));
               haveLast  = 1'b1;
               lastCycle = cycle;
               prevLast  = (wr_addr == AW'(DEPTH - 1));
            end
         end
      end
   end

   task automatic pushTable(logic [DW-1:0] b, logic [DW-1:0] m, int n);
      for (int j = 0; j < n; j++) expQ.push_back('{addr: AW'(j), data: expEntry(j, b, m)});
   endtask

   task automatic startTable(logic [DW-1:0] b, logic [DW-1:0] m);
      @(posedge clk);
      #1;
      base    = b;
      modulus = m;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      tableId++;
      checkOutput("first write latency", DW'(wr_en), DW'(1));
      checkOutput("busy after start", DW'(busy), DW'(1));
   endtask

   task automatic applyStimulus(logic [DW-1:0] b, logic [DW-1:0] m, int n, int gap);
      pushTable(b, m, n);
      expGap = gap;
      startTable(b, m);
   endtask

   task automatic waitDone(string name);
      bit seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL %s timeout: done=0, expected done within 400 cycles", name);
      end
      #4;
      checkOutput({name, " queue drained"}, DW'(expQ.size()), '0);
   endtask

   task automatic waitPresented(int addr, string name);
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (wr_en && wr_addr == AW'(addr)) seen = 1'b1;
      end
      testsRun++;
      if (!seen) begin
         testsFailed++;
         $display("[TB] FAIL %s timeout: index %0d never presented, expected within 200 cycles", name, addr);
      end
   endtask

   initial begin
      logic [DW-1:0] b1, m1, bw, mw, sd;

`ifdef XPB_GEN_REDUCE_EN
      b1 = DW'(3);
      m1 = DW'(7);
      mw = '1;
      bw = mw - DW'(1);
`else
      b1 = DW'(1);
      m1 = '0;
      bw = '1;
      mw = '0;
`endif

      #1;
      reset = 1'b1;
      #1;
      checkOutput("reset wr_en", DW'(wr_en), '0);
      checkOutput("reset busy", DW'(busy), '0);
      checkOutput("reset done", DW'(done), '0);
      checkOutput("reset wr_addr", DW'(wr_addr), '0);
      checkOutput("reset wr_data", wr_data, '0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] basic table");
      applyStimulus(b1, m1, DEPTH, GAP);
      waitDone("basic");

      $display("[TB] back-pressure at index 4");
      applyStimulus(DW'(5), DW'(11), DEPTH, 0);
      sd = expEntry(4, DW'(5), DW'(11));
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            #2;
            if (wr_en && wr_addr == AW'(4)) hit = 1'b1;
         end
         testsRun++;
         if (!hit) begin
            testsFailed++;
            $display("[TB] FAIL stall timeout: index 4 never presented, expected within 200 cycles");
         end
      end
      for (int i = 0; i < 5; i++) begin
         wr_ready = 1'b0;
         checkOutput("stall wr_en", DW'(wr_en), DW'(1));
         checkOutput("stall wr_addr", DW'(wr_addr), DW'(4));
         checkOutput("stall wr_data", wr_data, sd);
         @(negedge clk);
         #2;
      end
      wr_ready = 1'b1;
      waitDone("backpressure");

      $display("[TB] start while busy");
      applyStimulus(DW'(7), DW'(13), DEPTH, GAP);
      waitPresented(10, "busy start");
      base  = DW'(2);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      base  = DW'(7);
      waitDone("start while busy");

      $display("[TB] wrap table");
      applyStimulus(bw, mw, DEPTH, GAP);
      waitDone("wrap");

      $display("[TB] reset mid-table");
      applyStimulus(DW'(9), DW'(23), 12, GAP);
      waitPresented(12, "reset wait");
      reset = 1'b1;
      #1;
      checkOutput("mid reset wr_en", DW'(wr_en), '0);
      checkOutput("mid reset busy", DW'(busy), '0);
      checkOutput("mid reset wr_addr", DW'(wr_addr), '0);
      checkOutput("mid reset wr_data", wr_data, '0);
      checkOutput("reset queue drained", DW'(expQ.size()), '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("post reset idle wr_en", DW'(wr_en), '0);
      checkOutput("post reset idle busy", DW'(busy), '0);

      $display("[TB] fresh table after reset");
      applyStimulus(b1, m1, DEPTH, GAP);
      waitDone("recovery");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
